uart_tx: RTL and testbench

Serial transmitter for the UART path, directly downstream of the baud rate generator. It consumes the generator's one-cycle baud tick and shifts out one byte per request as an 8N1 frame (8E1 when parity is compiled in). Data goes out LSB-first on a line that idles high. Bit boundaries are aligned to baud ticks, so every bit, including the start bit, lasts exactly one tick period.

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 (8E1 with UART_TX_PARITY_EN) UART transmitter, LSB first,
// bit boundaries aligned to the baud_tick pulses from the baud generator.
//
// Ports:
//   clk_in     : system clock, rising edge
//   reset      : synchronous active-low reset
//   baud_tick  : one-cycle pulse per bit period
//   tx_start   : transmit request, sampled only in IDLE
//   tx_data    : DATA_BITS-wide word, captured in the accept cycle
//   tx_busy    : high in every state except IDLE
//   tx_done    : one-cycle pulse when the stop bit completes
//   tx_out     : registered serial line, idles high
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).

module uart_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_out
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_STOP
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 done_q, done_d;
    logic                 last_bit;

`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // cnt_q counts data bits already shifted out; the last one is
    // on the line when it reaches DATA_BITS-1.
    assign last_bit = (cnt_q == 4'(DATA_BITS - 1));

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (tx_start)  state_d = S_ARM;
            S_ARM:   if (baud_tick) state_d = S_START;
            S_START: if (baud_tick) state_d = S_DATA;
            S_DATA: begin
                if (baud_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (baud_tick) state_d = S_STOP;
`endif
            S_STOP:  if (baud_tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values. tx_out_d is the level the line
    // takes for the state being entered, so the line changes on the
    // same edge as the state.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tx_out_d = tx_out_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (tx_start) begin
                    shift_d = tx_data;
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            S_ARM: begin
                if (baud_tick) tx_out_d = 1'b0;
            end
            S_START: begin
                if (baud_tick) tx_out_d = shift_q[0];
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 4'd1;
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        tx_out_d = par_q;
`else
                        tx_out_d = 1'b1;
`endif
                    end else begin
                        tx_out_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) tx_out_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    tx_out_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: tx_out_d = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done_q;
    assign tx_out  = tx_out_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with baud_tick every 4 cycles.
// Build with UART_TX_PARITY_EN defined to cover the parity frames.

module tb_uart_tx;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_out;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int tcnt = 0;

`ifdef UART_TX_PARITY_EN
    localparam int         NB     = 11;
    localparam logic [10:0] F_A5  = 11'b10101001010;
    localparam logic [10:0] F_3C  = 11'b10001111000;
    localparam logic [10:0] F_01  = 11'b11000000010;
`else
    localparam int         NB     = 10;
    localparam logic [10:0] F_A5  = 11'b01101001010;
    localparam logic [10:0] F_3C  = 11'b01001111000;
`endif

    uart_tx #(.DATA_BITS(8)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .baud_tick (baud_tick),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_out    (tx_out)
    );

    always #5 clk_in = ~clk_in;

    // Tick changes just after the rising edge, so it is stable at the
    // falling edge where stimulus is driven.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            baud_tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(negedge clk_in) if (tx_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk_in);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk_in);
        tx_start = 1'b0;
    endtask

    // Waits for the start bit, then checks each bit at its first
    // sampling point. inj >= 0 pulses tx_start with 0xFF during bit inj.
    task automatic check_frame(input string tag, input logic [10:0] exp,
                               input int inj);
        int k;
        k = 0;
        while (k < 50) begin
            @(negedge clk_in);
            if (tx_out === 1'b0) break;
            k++;
        end
        if (k >= 50) begin
            check({tag, "_start_timeout"}, 1, 0);
            return;
        end
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_b%0d", tag, i), tx_out, exp[i]);
            check($sformatf("%s_busy%0d", tag, i), tx_busy, 1);
            check($sformatf("%s_done%0d", tag, i), tx_done, 0);
            if (i == inj) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge clk_in);
                tx_start = 1'b0;
                repeat (3) @(negedge clk_in);
            end else begin
                repeat (4) @(negedge clk_in);
            end
        end
        check({tag, "_done"}, tx_done, 1);
        check({tag, "_busy_fall"}, tx_busy, 0);
        check({tag, "_line_idle"}, tx_out, 1);
        @(negedge clk_in);
        check({tag, "_done_1cyc"}, tx_done, 0);
    endtask

    initial begin
        int d0;
        reset    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk_in);
        check("rst_out", tx_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check("idle_out", tx_out, 1);
            check("idle_busy", tx_busy, 0);
            check("idle_done", tx_done, 0);
        end

        // Basic frame.
        d0 = done_cnt;
        send(8'hA5);
        check("acc_busy", tx_busy, 1);
        check_frame("a5", F_A5, -1);
        repeat (4) @(negedge clk_in);
        check("a5_ndone", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
        d0 = done_cnt;
        send(8'h01);
        check_frame("p01", F_01, -1);
        repeat (4) @(negedge clk_in);
        check("p01_ndone", done_cnt - d0, 1);
`endif

        // Mid-frame request is ignored.
        d0 = done_cnt;
        send(8'hA5);
        check_frame("ign", F_A5, 4);
        repeat (12) @(negedge clk_in);
        check("ign_ndone", done_cnt - d0, 1);
        check("ign_busy", tx_busy, 0);
        check("ign_line", tx_out, 1);

        // Request coincident with a tick: that tick is not consumed.
        k_wait_tick();
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk_in);
        tx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("coin_hold%0d", i), tx_out, 1);
            if (i < 3) @(negedge clk_in);
        end
        check_frame("coin", F_3C, -1);
        repeat (4) @(negedge clk_in);

        // Reset during data bit 3 abandons the frame.
        d0 = done_cnt;
        send(8'hA5);
        begin
            int k;
            k = 0;
            while (k < 50 && tx_out !== 1'b0) begin
                @(negedge clk_in);
                k++;
            end
            check("rst_mid_start", k < 50, 1);
        end
        repeat (17) @(negedge clk_in);
        check("rst_mid_busy_pre", tx_busy, 1);
        reset = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        check("rst_mid_out", tx_out, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_done", tx_done, 0);
        repeat (20) @(negedge clk_in);
        check("rst_mid_ndone", done_cnt - d0, 0);
        check("rst_mid_idle", tx_busy, 0);

        d0 = done_cnt;
        send(8'h3C);
        check_frame("post", F_3C, -1);
        repeat (4) @(negedge clk_in);
        check("post_ndone", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic k_wait_tick();
        int k;
        k = 0;
        @(negedge clk_in);
        while (k < 20 && baud_tick !== 1'b1) begin
            @(negedge clk_in);
            k++;
        end
        check("tick_seen", k < 20, 1);
    endtask

endmodule
